// File: rtl/memory_stage.sv
// Memory stage: 255-byte data RAM plus a memory-mapped output byte at 0xFF,
// pipeline registers toward writeback, and load/store counters.
module memory_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       stall,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic       ResultSrc_in,
    input  logic       RegWrite_in,
    input  logic [2:0] rd_in,
    input  logic [7:0] alu_result_in,
    input  logic [7:0] store_data,
    output logic       ResultSrc,
    output logic [7:0] alu_result,
    output logic [7:0] mem_data,
    output logic       RegWrite_out,
    output logic [2:0] rd_out,
    output logic [7:0] io_out,
    output logic [7:0] ld_count,
    output logic [7:0] st_count
);

    localparam logic [7:0] IO_ADDR = 8'hFF;

    logic [7:0] r_mem [0:254];
    logic       r_resultsrc_q;
    logic       w_accept;
    logic       w_is_io;
    logic       w_mem_we;
    logic [7:0] w_rd_byte;

    assign w_accept = in_valid & ~stall;
    assign w_is_io  = (alu_result_in == IO_ADDR);
    // Reset level gates the RAM so a store caught by reset is never committed.
    assign w_mem_we = w_accept & MemWrite & ~w_is_io & reset;

    // Read mux: old RAM/IO contents, giving read-before-write on a combined load+store.
    always_comb begin
        w_rd_byte = 8'h00;
        if (w_is_io) begin
            w_rd_byte = io_out;
        end else begin
            w_rd_byte = r_mem[alu_result_in];
        end
    end

    // Writeback select: live during normal flow, frozen copy while stalled.
    always_comb begin
        ResultSrc = 1'b0;
        if (!reset) begin
            ResultSrc = 1'b0;
        end else if (stall) begin
            ResultSrc = r_resultsrc_q;
        end else begin
            ResultSrc = ResultSrc_in & in_valid;
        end
    end

    // Data RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[alu_result_in] <= store_data;
        end
    end

    // Pipeline registers, IO port and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result    <= 8'h00;
            mem_data      <= 8'h00;
            RegWrite_out  <= 1'b0;
            rd_out        <= 3'd0;
            r_resultsrc_q <= 1'b0;
            io_out        <= 8'h00;
            ld_count      <= 8'h00;
            st_count      <= 8'h00;
        end else if (w_accept) begin
            alu_result    <= alu_result_in;
            RegWrite_out  <= RegWrite_in;
            rd_out        <= rd_in;
            r_resultsrc_q <= ResultSrc_in;
            if (MemRead) begin
                mem_data <= w_rd_byte;
                ld_count <= ld_count + 8'd1;
            end
            if (MemWrite) begin
                st_count <= st_count + 8'd1;
                if (w_is_io) begin
                    io_out <= store_data;
                end
            end
        end else if (!stall) begin
            // Bubble: kill the write enable and the held select, keep data.
            RegWrite_out  <= 1'b0;
            r_resultsrc_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a per-cycle model with a compare process on
// the falling edge, plus literal spot checks of the scenario outcomes.
module tb_memory_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, stall, MemRead, MemWrite, ResultSrc_in, RegWrite_in;
    logic [2:0] rd_in;
    logic [7:0] alu_result_in, store_data;
    logic       ResultSrc;
    logic [7:0] alu_result, mem_data, io_out, ld_count, st_count;
    logic       RegWrite_out;
    logic [2:0] rd_out;

    int vectors = 0;
    int fails   = 0;

    memory_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .MemRead(MemRead), .MemWrite(MemWrite), .ResultSrc_in(ResultSrc_in),
        .RegWrite_in(RegWrite_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
        .store_data(store_data), .ResultSrc(ResultSrc), .alu_result(alu_result),
        .mem_data(mem_data), .RegWrite_out(RegWrite_out), .rd_out(rd_out),
        .io_out(io_out), .ld_count(ld_count), .st_count(st_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the writeback side should see, from the stage's rules.
    logic [7:0] m_ram [0:255];
    bit         m_known [0:255];
    logic [7:0] m_alu = 8'h00, m_md = 8'h00, m_io = 8'h00;
    bit         m_md_known = 1'b1;
    logic       m_rw = 1'b0, m_rsq = 1'b0;
    logic [2:0] m_rd = 3'd0;
    int         m_ld = 0, m_st = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_alu = 8'h00; m_md = 8'h00; m_md_known = 1'b1; m_io = 8'h00;
            m_rw = 1'b0; m_rsq = 1'b0; m_rd = 3'd0; m_ld = 0; m_st = 0;
        end else if (in_valid && !stall) begin
            m_alu = alu_result_in; m_rw = RegWrite_in; m_rd = rd_in; m_rsq = ResultSrc_in;
            if (MemRead) begin
                m_ld++;
                if (alu_result_in == 8'hFF) begin
                    m_md = m_io; m_md_known = 1'b1;
                end else begin
                    m_md = m_ram[alu_result_in]; m_md_known = m_known[alu_result_in];
                end
            end
            if (MemWrite) begin
                m_st++;
                if (alu_result_in == 8'hFF) m_io = store_data;
                else begin
                    m_ram[alu_result_in] = store_data;
                    m_known[alu_result_in] = 1'b1;
                end
            end
        end else if (!stall) begin
            m_rw = 1'b0; m_rsq = 1'b0;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic exp_rs;
        exp_rs = !reset ? 1'b0 : (stall ? m_rsq : (ResultSrc_in & in_valid));
        chk("cyc_ResultSrc", 32'(ResultSrc), 32'(exp_rs));
        chk("cyc_alu_result", 32'(alu_result), 32'(m_alu));
        chk("cyc_RegWrite", 32'(RegWrite_out), 32'(m_rw));
        chk("cyc_rd_out", 32'(rd_out), 32'(m_rd));
        chk("cyc_io_out", 32'(io_out), 32'(m_io));
        chk("cyc_ld_count", 32'(ld_count), 32'(m_ld & 255));
        chk("cyc_st_count", 32'(st_count), 32'(m_st & 255));
        if (m_md_known) chk("cyc_mem_data", 32'(mem_data), 32'(m_md));
    end

    // Present one instruction for the next rising edge.
    task automatic drive(input logic v, input logic st, input logic mr, input logic mw,
                         input logic rs, input logic rw, input logic [2:0] rd,
                         input logic [7:0] addr, input logic [7:0] sd);
        @(posedge clk);
        #2;
        in_valid = v; stall = st; MemRead = mr; MemWrite = mw; ResultSrc_in = rs;
        RegWrite_in = rw; rd_in = rd; alu_result_in = addr; store_data = sd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m_ram[i] = 8'h00; m_known[i] = 1'b0; end
        reset = 1'b0;
        in_valid = 1'b0; stall = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ResultSrc_in = 1'b0;
        RegWrite_in = 1'b0; rd_in = 3'd0; alu_result_in = 8'h00; store_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_alu", 32'(alu_result), 32'h0);
        chk("rst_ld", 32'(ld_count), 32'h0);
        #1 reset = 1'b1;

        // Store then back-to-back load with writeback select.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 8'h5A);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h10, 8'h00);
        #1 chk("lit_load_rs", 32'(ResultSrc), 32'h1);
        idle();
        chk("lit_load_data", 32'(mem_data), 32'h5A);
        chk("lit_ld1", 32'(ld_count), 32'h1);
        chk("lit_st1", 32'(st_count), 32'h1);

        // Plain ALU op.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h33, 8'h00);
        #1 chk("lit_alu_rs", 32'(ResultSrc), 32'h0);
        idle();
        chk("lit_alu", 32'(alu_result), 32'h33);
        chk("lit_alu_rw", 32'(RegWrite_out), 32'h1);
        chk("lit_alu_rd", 32'(rd_out), 32'h3);
        chk("lit_alu_md_hold", 32'(mem_data), 32'h5A);

        // Store stalled for three cycles, then released.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h44, 8'h00);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h20, 8'h77);
        #1 chk("lit_stall_rs", 32'(ResultSrc), 32'h1);
        chk("lit_stall_st", 32'(st_count), 32'h1);
        chk("lit_stall_alu", 32'(alu_result), 32'h44);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h20, 8'h77);
        idle();
        chk("lit_stall_st2", 32'(st_count), 32'h2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h20, 8'h00);
        idle();
        chk("lit_stall_load", 32'(mem_data), 32'h77);

        // IO port store and load back.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hA5);
        idle();
        chk("lit_io", 32'(io_out), 32'hA5);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'hFF, 8'h00);
        idle();
        chk("lit_io_load", 32'(mem_data), 32'hA5);

        // Combined load+store: old byte returned, both counters step.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 8'h10, 8'h99);
        idle();
        chk("lit_rmw_old", 32'(mem_data), 32'h5A);
        chk("lit_rmw_ld", 32'(ld_count), 32'h4);
        chk("lit_rmw_st", 32'(st_count), 32'h4);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00);
        idle();
        chk("lit_rmw_new", 32'(mem_data), 32'h99);

        // Reset mid-store between edges: store must be dropped.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h30, 8'h11);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h30, 8'hEE);
        #2 reset = 1'b0;
        #1 chk("lit_rst_alu", 32'(alu_result), 32'h0);
        chk("lit_rst_io", 32'(io_out), 32'h0);
        chk("lit_rst_st", 32'(st_count), 32'h0);
        chk("lit_rst_rs", 32'(ResultSrc), 32'h0);
        @(posedge clk);
        #1 chk("lit_rst_rs_hold", 32'(ResultSrc), 32'h0);
        in_valid = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;

        // First edge after release accepts; 256 loads wrap ld_count.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h30, 8'h00);
        idle();
        chk("lit_rst_dropped", 32'(mem_data), 32'h11);
        chk("lit_rst_ld1", 32'(ld_count), 32'h1);
        for (int i = 0; i < 254; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h30, 8'h00);
        idle();
        chk("lit_ld_ff", 32'(ld_count), 32'hFF);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h30, 8'h00);
        idle();
        chk("lit_ld_wrap", 32'(ld_count), 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- in_valid  in  1  instruction present in MEM this cycle
- stall  in  1  hold stage; accept nothing
- MemRead  in  1  load
- MemWrite  in  1  store
- ResultSrc_in  in  1  0 = ALU result, 1 = memory data
- RegWrite_in  in  1  instruction writes register file
- rd_in  in  3  destination register
- alu_result_in  in  8  ALU result; byte address for load/store
- store_data  in  8  store data
- ResultSrc  out  1  select to writeback stage, aligned one cycle ahead of data
- alu_result  out  8  registered ALU result
- mem_data  out  8  registered load data
- RegWrite_out  out  1  registered write enable
- rd_out  out  3  registered destination
- io_out  out  8  memory-mapped output port
- ld_count  out  8  completed-load counter
- st_count  out  8  completed-store counter

Function
REQ-003 Accept = in_valid & ~stall; the stage SHALL change state only on an accepted cycle.
REQ-004 Data memory SHALL be 255 x 8, addresses 0x00-0xFE, with synchronous write and registered read; contents are not reset.
REQ-005 Address 0xFF SHALL be io_out: a store writes it; a load returns the current io_out value.
REQ-006 Store (accept & MemWrite) SHALL write store_data at the rising edge ending the accept cycle, exactly once.
REQ-007 Load (accept & MemRead) SHALL register the read byte into mem_data at that same edge, giving 1-cycle latency.
REQ-008 On a load, mem_data SHALL reflect all stores accepted in earlier cycles; back-to-back store then load to the same address returns the stored byte.
REQ-009 If MemRead and MemWrite are both 1: the store SHALL be performed, and mem_data SHALL return the old byte (read-before-write).
REQ-010 On accept, alu_result, RegWrite_out and rd_out SHALL register their inputs.
REQ-011 On accept without MemRead, mem_data SHALL hold its previous value.
REQ-012 In a non-accepted cycle with stall=0 (bubble), RegWrite_out SHALL register 0 and the other outputs SHALL hold.
REQ-013 ResultSrc SHALL be combinational:
- stall=0: ResultSrc_in & in_valid
- stall=1: ResultSrc_q, the registered select of the last accepted instruction (0 after a bubble)
REQ-014 Consequence of REQ-013: ResultSrc during cycle T pairs with alu_result/mem_data during T+1, matching the writeback stage's one-cycle select delay.
REQ-015 During stall=1: no memory write; all registered outputs, counters and io_out SHALL hold.
REQ-016 ld_count SHALL increment per accepted load; st_count per accepted store; both wrap 0xFF -> 0x00.
REQ-017 When MemRead and MemWrite are both 1, both counters SHALL increment.
REQ-018 alu_result_in SHALL pass unmodified; no arithmetic is performed on it.

Reset
REQ-019 reset=0 SHALL immediately clear: alu_result, mem_data, rd_out, RegWrite_out, ResultSrc_q, io_out, ld_count, st_count.
REQ-020 While reset=0, ResultSrc SHALL be 0 and no memory write SHALL occur.
REQ-021 Reset asserted mid-operation SHALL drop any in-flight store not yet clocked.
REQ-022 After reset release, the first rising edge SHALL be able to accept.

Verification
REQ-023 Store 0x5A to 0x10, then next cycle load 0x10 with ResultSrc_in=1:
- ResultSrc=1 in the load cycle
- mem_data=0x5A the following cycle
- ld_count=1, st_count=1
REQ-024 ALU op (alu_result_in=0x33, RegWrite_in=1, rd_in=3, ResultSrc_in=0):
- next cycle: alu_result=0x33, RegWrite_out=1, rd_out=3, ResultSrc was 0
REQ-025 Store 0x77 to 0x20 with stall=1 for 3 cycles, then stall=0:
- exactly one write occurs, st_count=1
- outputs frozen during the stall
- a later load of 0x20 returns 0x77
REQ-026 Store 0xA5 to 0xFF:
- io_out=0xA5 next cycle
- load 0xFF returns 0xA5
REQ-027 Issue 256 loads:
- ld_count wraps to 0x00
REQ-028 Assert reset low mid-store, asynchronously between edges:
- all outputs clear to 0 immediately
- ResultSrc=0 while reset is low
- the store is not performed
